// File: rtl/pc_fetch_unit.sv
// Architectural PC register and instruction-fetch FSM for the multi-cycle MIPS core.
// Optional wait-state timeout is enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        fetch_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        pc_misalign,
    output logic        fetch_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] addr_r;
    logic [31:0] pend_pc_r;
    logic        pend_r;
    logic        misalign_r;
    logic        exit_s;
    logic        timeout_s;
    logic        load_s;
    logic [31:0] load_val_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
    logic [CNT_W-1:0] wait_cnt_r;
    logic             err_r;

    // Counts not-ready cycles of the fetch in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !imem_ready) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && !imem_ready &&
                       (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));

    // One-cycle error pulse following an aborted fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= timeout_s;
        end
    end

    assign fetch_err = err_r;
`else
    // TIMEOUT_CYCLES has no effect here: WAIT holds until memory answers
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
    assign fetch_err = 1'b0;
`endif

    assign exit_s = (state_r == ST_WAIT) && (imem_ready || timeout_s);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; fetch_req is only honoured in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req) state_s = ST_WAIT;
                else           state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (imem_ready)     state_s = ST_DONE;
                else if (timeout_s) state_s = ST_IDLE;
                else                state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
        fetch_done = 1'b0;
        case (state_r)
            ST_IDLE: fetch_busy = 1'b0;
            ST_WAIT: begin
                imem_req   = 1'b1;
                fetch_busy = 1'b1;
            end
            ST_DONE: begin
                fetch_busy = 1'b1;
                fetch_done = 1'b1;
            end
            default: fetch_busy = 1'b0;
        endcase
    end

    // PC load select: a write in the exit cycle beats an older pending one
    always_comb begin
        load_s     = 1'b0;
        load_val_s = next_pc;
        case (state_r)
            ST_IDLE, ST_DONE: load_s = pc_write;
            ST_WAIT: begin
                if (exit_s && pc_write) begin
                    load_s = 1'b1;
                end else if (exit_s && pend_r) begin
                    load_s     = 1'b1;
                    load_val_s = pend_pc_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    // PC, IR, fetch address and deferred PC write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            ir_r       <= NOP_INSTR;
            addr_r     <= RESET_PC;
            pend_pc_r  <= 32'h0000_0000;
            pend_r     <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            if (load_s) begin
                pc_r       <= {load_val_s[31:2], 2'b00};
                misalign_r <= misalign_r | (load_val_s[1:0] != 2'b00);
            end
            if ((state_r == ST_IDLE) && fetch_req) begin
                addr_r <= pc_r;
            end
            if ((state_r == ST_WAIT) && imem_ready) begin
                ir_r <= imem_rdata;
            end else if (timeout_s) begin
                ir_r <= NOP_INSTR;
            end
            if ((state_r == ST_WAIT) && !exit_s && pc_write) begin
                pend_r    <= 1'b1;
                pend_pc_r <= next_pc;
            end else if (exit_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_r + 32'd4;
    assign ir          = ir_r;
    assign imem_addr   = addr_r;
    assign pc_misalign = misalign_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level model checked every cycle
// plus literal expectations; timeout scenario runs when FETCH_TIMEOUT_EN is defined.
module tb_pc_fetch_unit;
    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int          TO  = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, pc_write, fetch_req, imem_ready;
    logic [31:0] next_pc, imem_rdata;
    logic        imem_req, fetch_busy, fetch_done, pc_misalign, fetch_err;
    logic [31:0] imem_addr, pc, pc_plus4, ir;

    int n_pass  = 0;
    int n_total = 0;

    pc_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_write(pc_write),
        .fetch_req(fetch_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
        .ir(ir), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
        .pc_misalign(pc_misalign), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: PC, IR and the fetch described as a transaction with a queue of deferred writes
    logic [31:0] m_pc, m_ir, m_addr;
    bit          m_mis, m_fetch, m_done, m_err, m_valid;
    int          m_wait;
    logic [31:0] pend_q[$];

    task automatic load_pc(input logic [31:0] v);
        m_pc = {v[31:2], 2'b00};
        if (v[1:0] != 2'b00) m_mis = 1'b1;
    endtask

    // Inputs are stable between posedge+1 and the next posedge, so at the negedge
    // the model compares the last edge's outcome and then predicts the next edge.
    initial begin
        m_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("pc", pc, m_pc);
                chk("pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("ir", ir, m_ir);
                chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetch});
                if (m_fetch) chk("imem_addr", imem_addr, m_addr);
                chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, m_fetch | m_done});
                chk("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
                chk("pc_misalign", {31'd0, pc_misalign}, {31'd0, m_mis});
                chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
            end
            if (!rst_n) begin
                m_pc = RPC; m_ir = NOP; m_addr = RPC; m_mis = 1'b0;
                m_fetch = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wait = 0;
                pend_q.delete();
                m_valid = 1'b1;
            end else if (m_valid) begin
                bit done_now, err_now, finish;
                done_now = 1'b0; err_now = 1'b0; finish = 1'b0;
                if (m_fetch) begin
                    if (pc_write) pend_q.push_back(next_pc);
                    if (imem_ready) begin
                        m_ir = imem_rdata; done_now = 1'b1; finish = 1'b1;
                    end else begin
                        m_wait++;
                        if (TO_EN && m_wait == TO) begin
                            m_ir = NOP; err_now = 1'b1; finish = 1'b1;
                        end
                    end
                    if (finish) begin
                        if (pend_q.size() > 0) load_pc(pend_q[$]);
                        pend_q.delete();
                        m_fetch = 1'b0;
                    end
                end else begin
                    if (fetch_req && !m_done) begin
                        m_fetch = 1'b1; m_addr = m_pc; m_wait = 0;
                    end
                    if (pc_write) load_pc(next_pc);
                end
                m_done = done_now;
                m_err  = err_now;
            end
        end
    end

    initial begin
        rst_n = 1'b0; pc_write = 1'b0; fetch_req = 1'b0; imem_ready = 1'b0;
        next_pc = 32'h0; imem_rdata = 32'h0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_ir", ir, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        rst_n = 1'b1;

        // Zero-wait fetch: done two cycles after the request
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        chk("zw_req", {31'd0, imem_req}, 32'd1);
        chk("zw_addr", imem_addr, 32'h0040_0000);
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005; tick(); imem_ready = 1'b0;
        chk("zw_done", {31'd0, fetch_done}, 32'd1);
        chk("zw_ir", ir, 32'h2008_0005);
        tick();
        chk("zw_done_off", {31'd0, fetch_done}, 32'd0);

        // Deferred PC write during three wait states
        pc_write = 1'b1; next_pc = 32'h0000_0100; tick(); pc_write = 1'b0;
        chk("def_pc0", pc, 32'h0000_0100);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        pc_write = 1'b1; next_pc = 32'h0000_0200; tick(); pc_write = 1'b0;
        chk("def_addr1", imem_addr, 32'h0000_0100);
        chk("def_pc1", pc, 32'h0000_0100);
        tick();
        chk("def_addr2", imem_addr, 32'h0000_0100);
        imem_ready = 1'b1; imem_rdata = 32'h8C08_0000; tick(); imem_ready = 1'b0;
        chk("def_done", {31'd0, fetch_done}, 32'd1);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        chk("def_pc_after", pc, 32'h0000_0200);
        chk("def_req_ignored", {31'd0, fetch_busy}, 32'd0);

        // Fetch and write together use the old PC; last of several deferred writes wins
        fetch_req = 1'b1; pc_write = 1'b1; next_pc = 32'h0000_0300; tick(); fetch_req = 1'b0;
        chk("same_addr", imem_addr, 32'h0000_0200);
        chk("same_pc", pc, 32'h0000_0300);
        next_pc = 32'h0000_0400; tick();
        next_pc = 32'h0000_0404; tick(); pc_write = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h0000_000C; tick(); imem_ready = 1'b0;
        chk("last_wins", pc, 32'h0000_0404);
        tick();

        // Misaligned load and PC+4 wrap
        pc_write = 1'b1; next_pc = 32'hFFFF_FFFE; tick(); pc_write = 1'b0;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        chk("misalign", {31'd0, pc_misalign}, 32'd1);

        // Reset in the middle of a fetch
        fetch_req = 1'b1; tick(); fetch_req = 1'b0; tick();
        rst_n = 1'b0; imem_ready = 1'b1; tick(); rst_n = 1'b1;
        chk("mr_req", {31'd0, imem_req}, 32'd0);
        chk("mr_pc", pc, 32'h0040_0000);
        chk("mr_mis", {31'd0, pc_misalign}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_done", {31'd0, fetch_done}, 32'd0);
        end
        imem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Timeout abort after four wait cycles
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678; tick(); imem_ready = 1'b0; tick();
        chk("to_ir_pre", ir, 32'h1234_5678);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        repeat (TO) tick();
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_ir", ir, 32'h0000_0000);
        chk("to_busy", {31'd0, fetch_busy}, 32'd0);
        chk("to_done", {31'd0, fetch_done}, 32'd0);
        tick();
        chk("to_err_off", {31'd0, fetch_err}, 32'd0);
`endif

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
